// File: rtl/chip.sv
// Single-tile Sobel edge engine: loads a 20x20 tile five pixels per clock, then
// streams an 18x18 thresholded L1-gradient edge map one bit per clock.
module chip #(
    parameter int BIT_LENGTH = 4,
    parameter int THRESH     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BIT_LENGTH-1:0] pixel_in0,
    input  logic [BIT_LENGTH-1:0] pixel_in1,
    input  logic [BIT_LENGTH-1:0] pixel_in2,
    input  logic [BIT_LENGTH-1:0] pixel_in3,
    input  logic [BIT_LENGTH-1:0] pixel_in4,
    input  logic                  load_end,
    output logic                  edge_out,
    output logic                  readable
);

    localparam int SW    = BIT_LENGTH + 4;   // holds 4*max pixel plus sign
    localparam int WORDS = 80;
    localparam int LAST  = 17;

    typedef enum logic [1:0] {S_LOAD, S_OUT, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [6:0]            word_q, word_d;
    logic [4:0]            row_q, row_d;
    logic [4:0]            col_q, col_d;
    logic                  edge_q, edge_d;
    logic                  rd_q, rd_d;

    logic [BIT_LENGTH-1:0] pix_q [400];
    logic [BIT_LENGTH-1:0] word_in [5];

    assign word_in[0] = pixel_in0;
    assign word_in[1] = pixel_in1;
    assign word_in[2] = pixel_in2;
    assign word_in[3] = pixel_in3;
    assign word_in[4] = pixel_in4;

    // Word j occupies flat slots 5j..5j+4; on load_end the word also fills every later slot.
    // NOTE: the tile buffer has no reset; a full tile is always written before it is read.
    always_ff @(posedge clk) begin
        if (state_q == S_LOAD) begin
            for (int j = 0; j < WORDS; j++) begin
                if (7'(j) == word_q || (load_end && 7'(j) > word_q)) begin
                    for (int i = 0; i < 5; i++) begin
                        pix_q[j*5+i] <= word_in[i];
                    end
                end
            end
        end
    end

    logic [8:0]    base;
    logic [SW-1:0] win [9];
    logic [SW-1:0] gx_pos, gx_neg, gy_pos, gy_neg;
    logic [SW-1:0] gx, gy, ax, ay, mag;
    logic          edge_bit;

    always_comb begin
        base = 9'(row_q) * 9'd20 + 9'(col_q);
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                win[dr*3+dc] = SW'(pix_q[base + 9'(dr*20 + dc)]);
            end
        end
        gx_pos   = win[2] + (win[5] << 1) + win[8];
        gx_neg   = win[0] + (win[3] << 1) + win[6];
        gy_pos   = win[6] + (win[7] << 1) + win[8];
        gy_neg   = win[0] + (win[1] << 1) + win[2];
        gx       = gx_pos - gx_neg;
        gy       = gy_pos - gy_neg;
        ax       = gx[SW-1] ? SW'(-gx) : gx;
        ay       = gy[SW-1] ? SW'(-gy) : gy;
        mag      = ax + ay;
        edge_bit = (mag >= SW'(THRESH));
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        row_d   = row_q;
        col_d   = col_q;
        edge_d  = 1'b0;
        rd_d    = 1'b0;
        unique case (state_q)
            S_LOAD: begin
                word_d = word_q + 7'd1;
                if (load_end || word_q == 7'(WORDS - 1)) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                edge_d = edge_bit;
                rd_d   = 1'b1;
                if (col_q == 5'(LAST)) begin
                    col_d = 5'd0;
                    if (row_q == 5'(LAST)) begin
                        state_d = S_DONE;
                    end else begin
                        row_d = row_q + 5'd1;
                    end
                end else begin
                    col_d = col_q + 5'd1;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_LOAD;
            word_q  <= 7'd0;
            row_q   <= 5'd0;
            col_q   <= 5'd0;
            edge_q  <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            row_q   <= row_d;
            col_q   <= col_d;
            edge_q  <= edge_d;
            rd_q    <= rd_d;
        end
    end

    assign edge_out = edge_q;
    assign readable = rd_q;

endmodule

// File: tb/tb_chip.sv
// Scoreboard bench for chip: two instances (THRESH 32 and 8) share stimulus; a
// forked monitor pops expected edge bits on each falling edge while readable.
module tb_chip;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] p0, p1, p2, p3, p4;
    logic       load_end;
    logic       e32, r32, e8, r8;

    always #5 clk = ~clk;

    chip #(.BIT_LENGTH(4), .THRESH(32)) dut32 (
        .clk(clk), .reset(reset),
        .pixel_in0(p0), .pixel_in1(p1), .pixel_in2(p2), .pixel_in3(p3), .pixel_in4(p4),
        .load_end(load_end), .edge_out(e32), .readable(r32)
    );

    chip #(.BIT_LENGTH(4), .THRESH(8)) dut8 (
        .clk(clk), .reset(reset),
        .pixel_in0(p0), .pixel_in1(p1), .pixel_in2(p2), .pixel_in3(p3), .pixel_in4(p4),
        .load_end(load_end), .edge_out(e8), .readable(r8)
    );

    int tile_in  [20][20];
    int tile_eff [20][20];
    bit exp32[$];
    bit exp8[$];
    int n_cmp, n_fail;
    int rd32, rd8, ones32;
    int base32, base8, base_ones;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int word_px(input int k, input int i);
        return tile_in[k/4][5*(k%4)+i];
    endfunction

    task automatic build_eff(input int last);
        for (int k = 0; k < 80; k++) begin
            int src;
            src = (k <= last) ? k : last;
            for (int i = 0; i < 5; i++) tile_eff[k/4][5*(k%4)+i] = word_px(src, i);
        end
    endtask

    function automatic bit model(input int r, input int c, input int thr);
        int gx, gy;
        gx = (tile_eff[r][c+2] + 2*tile_eff[r+1][c+2] + tile_eff[r+2][c+2])
           - (tile_eff[r][c]   + 2*tile_eff[r+1][c]   + tile_eff[r+2][c]);
        gy = (tile_eff[r+2][c] + 2*tile_eff[r+2][c+1] + tile_eff[r+2][c+2])
           - (tile_eff[r][c]   + 2*tile_eff[r][c+1]   + tile_eff[r][c+2]);
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        return (gx + gy) >= thr;
    endfunction

    task automatic push_model(input int last);
        build_eff(last);
        for (int r = 0; r < 18; r++)
            for (int c = 0; c < 18; c++) begin
                exp32.push_back(model(r, c, 32));
                exp8.push_back(model(r, c, 8));
            end
    endtask

    task automatic drive_word(input int k, input bit le);
        p0 = 4'(word_px(k, 0));
        p1 = 4'(word_px(k, 1));
        p2 = 4'(word_px(k, 2));
        p3 = 4'(word_px(k, 3));
        p4 = 4'(word_px(k, 4));
        load_end = le;
    endtask

    task automatic load_tile(input int last, input bit use_le);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("reset_readable32", r32, 0);
        check("reset_edge32", e32, 0);
        check("reset_readable8", r8, 0);
        base32 = rd32; base8 = rd8; base_ones = ones32;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        drive_word(0, use_le && last == 0);
        for (int k = 1; k <= last; k++) begin
            @(posedge clk);
            #1 drive_word(k, use_le && k == last);
        end
        @(posedge clk);
        #1 load_end = 1'b0;
        @(negedge clk);
        check("latency_gap_readable", r32, 0);
        @(negedge clk);
        check("latency_first_readable32", r32, 1);
        check("latency_first_readable8", r8, 1);
    endtask

    task automatic finish_tile(input string tag, input int want_ones);
        int budget;
        budget = 0;
        while ((r32 || r8) && budget < 400) begin
            @(negedge clk);
            budget++;
        end
        check({tag, "_end_in_time"}, int'(budget < 400), 1);
        check({tag, "_len32"}, rd32 - base32, 324);
        check({tag, "_len8"}, rd8 - base8, 324);
        check({tag, "_left32"}, exp32.size(), 0);
        check({tag, "_left8"}, exp8.size(), 0);
        if (want_ones >= 0) check({tag, "_ones32"}, ones32 - base_ones, want_ones);
        repeat (5) @(negedge clk);
        check({tag, "_done_readable"}, int'(r32 | r8), 0);
        check({tag, "_done_edge"}, int'(e32 | e8), 0);
    endtask

    task automatic random_tile();
        for (int r = 0; r < 20; r++)
            for (int c = 0; c < 20; c++) tile_in[r][c] = int'($urandom_range(0, 15));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_fail = 0; rd32 = 0; rd8 = 0; ones32 = 0;
        reset = 1'b0; load_end = 1'b0;
        p0 = '0; p1 = '0; p2 = '0; p3 = '0; p4 = '0;

        fork
            forever begin
                @(negedge clk);
                if (r32) begin
                    rd32++;
                    if (e32) ones32++;
                    if (exp32.size() == 0) check("edge32_pending", 0, int'(r32));
                    else check("edge32", e32, exp32.pop_front());
                end
                if (r8) begin
                    rd8++;
                    if (exp8.size() == 0) check("edge8_pending", 0, int'(r8));
                    else check("edge8", e8, exp8.pop_front());
                end
            end
        join_none

        // All-zero tile, load_end on word 79.
        for (int r = 0; r < 20; r++) for (int c = 0; c < 20; c++) tile_in[r][c] = 0;
        repeat (324) begin exp32.push_back(1'b0); exp8.push_back(1'b0); end
        load_tile(79, 1'b1);
        finish_tile("zero", 0);

        // Vertical step between columns 9 and 10: mag 60 at c=8 and c=9.
        for (int r = 0; r < 20; r++) for (int c = 0; c < 20; c++) tile_in[r][c] = (c >= 10) ? 15 : 0;
        for (int r = 0; r < 18; r++)
            for (int c = 0; c < 18; c++) begin
                exp32.push_back(c == 8 || c == 9);
                exp8.push_back(c == 8 || c == 9);
            end
        load_tile(79, 1'b1);
        finish_tile("step", 36);

        // Clipped ramp, 80 words with no load_end: mag 8 while unclipped (c<=13).
        for (int r = 0; r < 20; r++) for (int c = 0; c < 20; c++) tile_in[r][c] = (c > 15) ? 15 : c;
        for (int r = 0; r < 18; r++)
            for (int c = 0; c < 18; c++) begin
                exp32.push_back(1'b0);
                exp8.push_back(c <= 13);
            end
        load_tile(79, 1'b0);
        finish_tile("ramp", 0);

        // load_end on word 78: slot 79 (row 19, cols 15..19) replicates word 78.
        random_tile();
        for (int i = 0; i < 5; i++) begin
            tile_in[19][10+i] = 15 - i;
            tile_in[19][15+i] = i;
        end
        push_model(78);
        load_tile(78, 1'b1);
        finish_tile("repl78", -1);

        // Asynchronous reset after 100 streamed bits.
        random_tile();
        push_model(79);
        load_tile(79, 1'b1);
        begin
            int budget;
            budget = 0;
            while ((rd32 - base32) < 100 && budget < 200) begin
                @(negedge clk);
                budget++;
            end
            check("midout_reach100", int'(budget < 200), 1);
        end
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("midout_readable32", r32, 0);
        check("midout_edge32", e32, 0);
        check("midout_readable8", r8, 0);
        check("midout_edge8", e8, 0);
        exp32.delete();
        exp8.delete();

        random_tile();
        push_model(79);
        load_tile(79, 1'b1);
        finish_tile("after_abort", -1);

        // Back-to-back tiles with reset between each.
        for (int t = 0; t < 100; t++) begin
            int last;
            bit le;
            random_tile();
            case (t % 3)
                0:       begin last = 79; le = 1'b0; end
                1:       begin last = 79; le = 1'b1; end
                default: begin last = int'($urandom_range(60, 78)); le = 1'b1; end
            endcase
            push_model(last);
            load_tile(last, le);
            finish_tile($sformatf("tile%0d", t), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
